// File: rtl/charging_pkg.sv
// Shared types and constants for the charging-station session sequencer.
package charging_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        LOAD     = 3'd2,
        CHARGING = 3'd3,
        PAUSED   = 3'd4,
        DONE     = 3'd5
    } stateT;

    localparam logic [3:0]  MODE_SHORT = 4'd1;
    localparam logic [3:0]  MODE_LONG  = 4'd2;
    localparam logic [11:0] TIME_ZERO  = 12'h000;

    function automatic logic mode_valid(input logic [3:0] mode);
        return (mode == MODE_SHORT) || (mode == MODE_LONG);
    endfunction

endpackage

// File: rtl/charging_tick_prescaler.sv
// Divides the system clock down to one tick per TICK_DIV enabled cycles.
module charging_tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clk,
    input  logic nReset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    // Tick is combinational so the owner can register its strobe on the wrap edge.
    assign tick = run && !clear && (count == LAST);

    always_ff @(posedge Clk) begin
        if (!nReset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/charging_session_ctrl.sv
// Charging session sequencer driving the countdown timer.
// Optional pause/resume on Stop/Start is enabled by defining CHARGE_PAUSE_EN.
module charging_session_ctrl
    import charging_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int ARM_TIMEOUT = 30,
    parameter int DONE_HOLD   = 100
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        CoinIn,
    input  logic [3:0]  ModeSel,
    input  logic        Start,
    input  logic        Stop,
    input  logic [11:0] PresentTime,
    output logic        CounterEnable,
    output logic [3:0]  CounterInput,
    output logic        TimerReset_n,
    output logic        Charging,
    output logic        Done,
    output logic        Refund,
    output logic [2:0]  State
);

    localparam int AW = $clog2(ARM_TIMEOUT + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

    stateT         state;
    logic [3:0]    modeLatch;
    logic [AW-1:0] armCnt;
    logic [HW-1:0] holdCnt;
    logic          ticked;
    logic          tick;
    logic          prescClear;
    logic          prescRun;
    logic          expire;

    assign prescClear   = (state == IDLE) || (state == LOAD);
    assign prescRun     = (state == ARMED) || (state == CHARGING);
    // Expiry only counts once the timer has actually been strobed this session.
    assign expire       = (PresentTime == TIME_ZERO) && ticked;
    assign TimerReset_n = nReset && (state != LOAD);
    assign CounterInput = modeLatch;
    assign State        = state;

    charging_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) prescaler (
        .Clk   (Clk),
        .nReset(nReset),
        .clear (prescClear),
        .run   (prescRun),
        .tick  (tick)
    );

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state         <= IDLE;
            modeLatch     <= MODE_SHORT;
            armCnt        <= '0;
            holdCnt       <= '0;
            ticked        <= 1'b0;
            CounterEnable <= 1'b0;
            Charging      <= 1'b0;
            Done          <= 1'b0;
            Refund        <= 1'b0;
        end else begin
            CounterEnable <= 1'b0;
            Charging      <= 1'b0;
            Done          <= 1'b0;
            Refund        <= 1'b0;
            holdCnt       <= '0;
            case (state)
                IDLE: begin
                    modeLatch <= MODE_SHORT;
                    armCnt    <= '0;
                    if (CoinIn) state <= ARMED;
                end
                ARMED: begin
                    if (mode_valid(ModeSel)) modeLatch <= ModeSel;
                    if (tick) armCnt <= armCnt + AW'(1);
                    if (Stop) begin
                        state  <= IDLE;
                        Refund <= 1'b1;
                    end else if (Start) begin
                        state <= LOAD;
                    end else if (tick && armCnt == ARM_LAST) begin
                        state  <= IDLE;
                        Refund <= 1'b1;
                    end
                end
                LOAD: begin
                    ticked   <= 1'b0;
                    state    <= CHARGING;
                    Charging <= 1'b1;
                end
                CHARGING: begin
                    if (tick) ticked <= 1'b1;
                    if (expire) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (Stop) begin
`ifdef CHARGE_PAUSE_EN
                        state <= PAUSED;
`else
                        state <= DONE;
                        Done  <= 1'b1;
`endif
                    end else begin
                        Charging      <= 1'b1;
                        CounterEnable <= tick;
                    end
                end
                PAUSED: begin
`ifdef CHARGE_PAUSE_EN
                    if (Stop) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (Start) begin
                        state    <= CHARGING;
                        Charging <= 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (holdCnt == HOLD_LAST) begin
                        state <= IDLE;
                    end else begin
                        holdCnt <= holdCnt + HW'(1);
                        Done    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
